// File: rtl/rom_to_ram_scaler.sv
// Streams a SRC_W x SRC_H frame from a synchronous ROM into a frame RAM with copy, replicate,
// decimate or block-average scaling at a runtime power-of-two factor.
module rom_to_ram_scaler #(
    parameter int unsigned SRC_W     = 160,
    parameter int unsigned SRC_H     = 120,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned ROM_LAT   = 2,
    parameter int unsigned MAX_LOG2F = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [1:0]        fac_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [PIX_W-1:0]  ram_data,
    output logic              ram_wren,
    output logic [9:0]        out_w,
    output logic [9:0]        out_h,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned AW = PIX_W + 2 * MAX_LOG2F;
    localparam int unsigned DW = (MAX_LOG2F > 0) ? MAX_LOG2F : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d, k_q, k_d;
    logic [9:0]         out_w_q, out_w_d, out_h_q, out_h_d;
    logic [9:0]         ox_q, ox_d, oy_q, oy_d;
    logic [DW-1:0]      di_q, di_d, dj_q, dj_d;
    logic [ADDR_W-1:0]  wa_q, wa_d, rom_addr_q, rom_addr_d;
    logic [ROM_LAT-1:0] pv_q, pv_d, pf_q, pf_d, pl_q, pl_d;
    logic [ADDR_W-1:0]  pa_q [ROM_LAT];
    logic [ADDR_W-1:0]  pa_d [ROM_LAT];
    logic [AW-1:0]      acc_q, acc_d;
    logic [ADDR_W-1:0]  ram_wraddr_q, ram_wraddr_d;
    logic [PIX_W-1:0]   ram_data_q, ram_data_d;
    logic               ram_wren_q, ram_wren_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [DW-1:0]      bmax;
    logic               first_t, last_blk, last_px, kill, issue;
    logic [AW-1:0]      acc_sum, rnd, sum_r;

    // Source pixel for output (x, y) and block offset (i, j); i/j are zero outside average mode.
    function automatic logic [ADDR_W-1:0] src_addr(input logic [1:0] md, input logic [1:0] k,
                                                   input logic [9:0] x, input logic [9:0] y,
                                                   input logic [DW-1:0] i, input logic [DW-1:0] j);
        logic [ADDR_W-1:0] sx, sy;
        unique case (md)
            2'b01: begin
                sx = ADDR_W'(x >> k);
                sy = ADDR_W'(y >> k);
            end
            2'b10, 2'b11: begin
                sx = (ADDR_W'(x) << k) + ADDR_W'(j);
                sy = (ADDR_W'(y) << k) + ADDR_W'(i);
            end
            default: begin
                sx = ADDR_W'(x);
                sy = ADDR_W'(y);
            end
        endcase
        return sy * ADDR_W'(SRC_W) + sx;
    endfunction

    always_comb begin
        state_d = state_q;  mode_d = mode_q;  k_d = k_q;
        out_w_d = out_w_q;  out_h_d = out_h_q;
        ox_d = ox_q;  oy_d = oy_q;  di_d = di_q;  dj_d = dj_q;
        wa_d = wa_q;  rom_addr_d = rom_addr_q;  acc_d = acc_q;
        ram_wraddr_d = ram_wraddr_q;  ram_data_d = ram_data_q;  ram_wren_d = 1'b0;
        err_d = 1'b0;
        acc_sum = '0;  rnd = '0;  sum_r = '0;

        bmax     = (mode_q == 2'b11) ? DW'((32'd1 << k_q) - 32'd1) : '0;
        first_t  = (di_q == '0) && (dj_q == '0);
        last_blk = (di_q == bmax) && (dj_q == bmax);
        last_px  = last_blk && (ox_q == out_w_q - 10'd1) && (oy_q == out_h_q - 10'd1);
        kill     = abort && ((state_q == StRun) || (state_q == StDrain));
        issue    = (state_q == StRun) && !abort;

        // Tag shift register runs in lockstep with the ROM's read latency.
        for (int i = 1; i < ROM_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pf_d[i] = pf_q[i-1];
            pl_d[i] = pl_q[i-1];
            pa_d[i] = pa_q[i-1];
        end
        pv_d[0] = issue;
        pf_d[0] = first_t;
        pl_d[0] = last_blk;
        pa_d[0] = wa_q;
        if (kill) pv_d = '0;

        if (issue) begin
            if (!last_blk) begin
                if (dj_q == bmax) begin
                    dj_d = '0;
                    di_d = di_q + DW'(1);
                end else begin
                    dj_d = dj_q + DW'(1);
                end
            end else begin
                di_d = '0;
                dj_d = '0;
                wa_d = last_px ? '0 : wa_q + ADDR_W'(1);
                if (ox_q == out_w_q - 10'd1) begin
                    ox_d = '0;
                    oy_d = (oy_q == out_h_q - 10'd1) ? 10'd0 : oy_q + 10'd1;
                end else begin
                    ox_d = ox_q + 10'd1;
                end
            end
            rom_addr_d = src_addr(mode_q, k_q, ox_d, oy_d, di_d, dj_d);
        end

        if (pv_q[ROM_LAT-1] && !kill) begin
            if (mode_q == 2'b11) begin
                acc_sum = pf_q[ROM_LAT-1] ? AW'(rom_data) : acc_q + AW'(rom_data);
                acc_d   = acc_sum;
                if (pl_q[ROM_LAT-1]) begin
                    rnd          = (k_q == 2'b00) ? '0 : AW'(1) << ({k_q, 1'b0} - 3'd1);
                    sum_r        = acc_sum + rnd;
                    ram_data_d   = PIX_W'(sum_r >> {k_q, 1'b0});
                    ram_wraddr_d = pa_q[ROM_LAT-1];
                    ram_wren_d   = 1'b1;
                end
            end else begin
                ram_data_d   = rom_data;
                ram_wraddr_d = pa_q[ROM_LAT-1];
                ram_wren_d   = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (32'(fac_sel) > MAX_LOG2F) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d = mode;
                        k_d    = (mode == 2'b00) ? 2'b00 : fac_sel;
                        unique case (mode)
                            2'b00: begin
                                out_w_d = 10'(SRC_W);
                                out_h_d = 10'(SRC_H);
                            end
                            2'b01: begin
                                out_w_d = 10'(SRC_W) << k_d;
                                out_h_d = 10'(SRC_H) << k_d;
                            end
                            default: begin
                                out_w_d = 10'(SRC_W) >> k_d;
                                out_h_d = 10'(SRC_H) >> k_d;
                            end
                        endcase
                        ox_d = '0;  oy_d = '0;  di_d = '0;  dj_d = '0;
                        wa_d = '0;  rom_addr_d = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun:   state_d = abort ? StIdle : (last_px ? StDrain : StRun);
            StDrain: state_d = abort ? StIdle : ((pv_q == '0) ? StDone : StDrain);
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;  mode_q <= '0;  k_q <= '0;
            out_w_q <= '0;  out_h_q <= '0;
            ox_q <= '0;  oy_q <= '0;  di_q <= '0;  dj_q <= '0;
            wa_q <= '0;  rom_addr_q <= '0;
            pv_q <= '0;  pf_q <= '0;  pl_q <= '0;  pa_q <= '{default: '0};
            acc_q <= '0;
            ram_wraddr_q <= '0;  ram_data_q <= '0;  ram_wren_q <= 1'b0;
            busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
        end else begin
            state_q <= state_d;  mode_q <= mode_d;  k_q <= k_d;
            out_w_q <= out_w_d;  out_h_q <= out_h_d;
            ox_q <= ox_d;  oy_q <= oy_d;  di_q <= di_d;  dj_q <= dj_d;
            wa_q <= wa_d;  rom_addr_q <= rom_addr_d;
            pv_q <= pv_d;  pf_q <= pf_d;  pl_q <= pl_d;  pa_q <= pa_d;
            acc_q <= acc_d;
            ram_wraddr_q <= ram_wraddr_d;  ram_data_q <= ram_data_d;  ram_wren_q <= ram_wren_d;
            busy_q <= busy_d;  done_q <= done_d;  err_q <= err_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign ram_wraddr = ram_wraddr_q;
    assign ram_data   = ram_data_q;
    assign ram_wren   = ram_wren_q;
    assign out_w      = out_w_q;
    assign out_h      = out_h_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rom_to_ram_scaler.sv
// Scoreboard bench for rom_to_ram_scaler: reference frames are computed from the scaling rules
// and queued at job start; a monitor pops and compares every RAM write.
module tb_rom_to_ram_scaler;
    localparam int SW = 8, SH = 4, PW = 8, AWD = 10, LAT = 2;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0] mode = 2'b00, fac_sel = 2'b00;
    logic [AWD-1:0] rom_addr, ram_wraddr;
    logic [PW-1:0] rom_data, ram_data, d1;
    logic ram_wren, busy, done, err;
    logic [9:0] out_w, out_h;

    always #5 clk = ~clk;

    rom_to_ram_scaler #(
        .SRC_W(SW), .SRC_H(SH), .PIX_W(PW), .ADDR_W(AWD), .ROM_LAT(LAT), .MAX_LOG2F(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
        .fac_sel(fac_sel), .rom_addr(rom_addr), .rom_data(rom_data), .ram_wraddr(ram_wraddr),
        .ram_data(ram_data), .ram_wren(ram_wren), .out_w(out_w), .out_h(out_h), .busy(busy),
        .done(done), .err(err)
    );

    logic [PW-1:0] rom [SW*SH];
    logic [PW-1:0] ram [1024];

    // Two-cycle synchronous ROM
    always @(posedge clk) begin
        d1       <= (int'(rom_addr) < SW * SH) ? rom[rom_addr] : '0;
        rom_data <= d1;
    end

    typedef struct {int addr; int data;} wr_t;
    wr_t exp_q[$];
    int n_cmp = 0, n_bad = 0, wr_cnt = 0, done_cnt = 0;

    task automatic check(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ram_wren) begin
            wr_t e;
            wr_cnt++;
            ram[ram_wraddr] = ram_data;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                         ram_wraddr, ram_data);
            end else begin
                e = exp_q.pop_front();
                if (int'(ram_wraddr) != e.addr || int'(ram_data) != e.data) begin
                    n_bad++;
                    $display("FAIL ram_write: got addr %0d data %0d, expected addr %0d data %0d",
                             ram_wraddr, ram_data, e.addr, e.data);
                end
            end
        end
    end

    // Reference frame from the scaling rules; also returns output size and ROM read count.
    task automatic push_expected(input int md, input int k, output int ow, output int oh,
                                 output int nreads);
        int kk, v, sum;
        kk = (md == 0) ? 0 : k;
        ow = (md == 0) ? SW : (md == 1) ? (SW << kk) : (SW >> kk);
        oh = (md == 0) ? SH : (md == 1) ? (SH << kk) : (SH >> kk);
        nreads = (md == 3) ? ow * oh * (1 << (2 * kk)) : ow * oh;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                if (md == 0) v = rom[oy * SW + ox];
                else if (md == 1) v = rom[(oy / (1 << kk)) * SW + ox / (1 << kk)];
                else if (md == 2) v = rom[(oy * (1 << kk)) * SW + ox * (1 << kk)];
                else begin
                    sum = 0;
                    for (int i = 0; i < (1 << kk); i++)
                        for (int j = 0; j < (1 << kk); j++)
                            sum += rom[(oy * (1 << kk) + i) * SW + ox * (1 << kk) + j];
                    v = (sum + (1 << (2 * kk)) / 2) / (1 << (2 * kk));
                end
                exp_q.push_back('{addr: oy * ow + ox, data: v});
            end
        end
    endtask

    task automatic run_job(input int md, input int k, input bit probe_start);
        int ow, oh, nreads, w0, d0, cyc;
        push_expected(md, k, ow, oh, nreads);
        w0 = wr_cnt;
        d0 = done_cnt;
        @(negedge clk);
        mode = 2'(md); fac_sel = 2'(k); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy_after_start", int'(busy), 1);
        check("out_w", int'(out_w), ow);
        check("out_h", int'(out_h), oh);
        while (!done && cyc < 5000) begin
            if (probe_start && cyc == 10) begin
                start = 1'b1; mode = 2'b11; fac_sel = 2'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("start_to_done_cycles", cyc, nreads + LAT + 2);
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        check("write_count", wr_cnt - w0, ow * oh);
        check("done_count", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int w0, d0, bad_w;
        for (int a = 0; a < SW * SH; a++) rom[a] = PW'(a);
        repeat (3) @(negedge clk);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_ram_wraddr", int'(ram_wraddr), 0);
        check("rst_ram_data", int'(ram_data), 0);
        check("rst_out_w", int'(out_w), 0);
        check("rst_out_h", int'(out_h), 0);
        check("rst_flags", int'({ram_wren, busy, done, err}), 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_job(0, 2, 0);
        for (int a = 0; a < SW * SH; a++) check("copy_ram", int'(ram[a]), a);

        run_job(1, 1, 0);
        check("zoom_ram9", int'(ram[9]), 4);
        check("zoom_ram17", int'(ram[17]), 0);
        check("zoom_ram127", int'(ram[127]), 31);

        run_job(2, 1, 0);
        check("dec_ram0", int'(ram[0]), 0);
        check("dec_ram3", int'(ram[3]), 6);
        check("dec_ram4", int'(ram[4]), 16);
        check("dec_ram7", int'(ram[7]), 22);

        run_job(3, 1, 0);
        check("avg_ram0", int'(ram[0]), 5);
        check("avg_ram7", int'(ram[7]), 27);

        // Illegal factor
        @(negedge clk);
        mode = 2'b01; fac_sel = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", int'(err), 1);
        check("err_busy", int'(busy), 0);
        @(negedge clk);
        check("err_one_cycle", int'(err), 0);
        check("err_still_idle", int'(busy), 0);

        // start while busy is ignored
        run_job(0, 0, 1);

        // Abort mid zoom-in, then a full rerun
        begin
            int ow, oh, nr;
            push_expected(1, 1, ow, oh, nr);
        end
        w0 = wr_cnt;
        d0 = done_cnt;
        @(negedge clk);
        mode = 2'b01; fac_sel = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        bad_w = 0;
        for (int i = 0; i < 10; i++) begin
            if (ram_wren || done || busy) bad_w++;
            @(negedge clk);
        end
        check("abort_quiet", bad_w, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_partial_writes", int'((wr_cnt - w0) > 0 && (wr_cnt - w0) < 128), 1);
        exp_q.delete();
        run_job(1, 1, 0);

        // Randomised jobs over random frames
        for (int t = 0; t < 14; t++) begin
            for (int a = 0; a < SW * SH; a++) rom[a] = PW'($urandom);
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0);
        end
        run_job(1, 2, 0);
        run_job(3, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
